// File: rtl/prog_modn_counter_pkg.sv
// Package for prog_modn_counter.
// Holds the run-control state type and the default parameter values shared by
// the interface, the counter top and the optional prescaler.
// Optional feature macro: MODN_PRESCALER_EN (see prog_modn_counter.sv).
package prog_modn_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } modn_state_t;

  localparam int WIDTH_DEF  = 10;
  localparam int WRAP_W_DEF = 8;
  localparam int PSC_W_DEF  = 8;

endpackage

// File: rtl/prog_modn_counter_if.sv
// Control/status interface of prog_modn_counter.
// Control inputs (clr, start, stop, en, down, one_shot, load) are plain levels
// sampled on every rising clock edge; there is no valid/ready handshake, a
// command is taken in the cycle it is high and all status outputs follow one
// cycle later.
// Signals:
//   master drives: clr, start, stop, en, down, one_shot, load, load_val, n,
//                  psc (only when MODN_PRESCALER_EN is defined)
//   slave drives : count, tc, busy, done, wraps, state (FSM debug view)
interface prog_modn_counter_if
  import prog_modn_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
`ifdef MODN_PRESCALER_EN
  , parameter int PSC_W = PSC_W_DEF
`endif
);

  logic              clr;
  logic              start;
  logic              stop;
  logic              en;
  logic              down;
  logic              one_shot;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  n;
`ifdef MODN_PRESCALER_EN
  logic [PSC_W-1:0]  psc;
`endif
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wraps;
  modn_state_t       state;

  modport master (
`ifdef MODN_PRESCALER_EN
    output psc,
`endif
    output clr, start, stop, en, down, one_shot, load, load_val, n,
    input  count, tc, busy, done, wraps, state
  );

  modport slave (
`ifdef MODN_PRESCALER_EN
    input  psc,
`endif
    input  clr, start, stop, en, down, one_shot, load, load_val, n,
    output count, tc, busy, done, wraps, state
  );

endinterface

// File: rtl/prog_modn_counter_prescaler.sv
// modn_prescaler: divides the enabled-cycle stream of the counter.
// Only built when MODN_PRESCALER_EN is defined.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear of the divider phase
//   en        cycle qualifier (counter in RUN and enabled)
//   psc       divide ratio minus one; 0 gives a strobe every enabled cycle
//   strobe    high on the enabled cycle that completes psc+1 enabled cycles
`ifdef MODN_PRESCALER_EN
module modn_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  output logic             strobe
);

  logic [PSC_W-1:0] cnt;

  // >= rather than == so a psc lowered below the current phase recovers at once
  assign strobe = en & (cnt >= psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= strobe ? '0 : cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/prog_modn_counter.sv
// prog_modn_counter: run-controlled programmable modulo-n up/down counter.
// Counts over 0..n-1 (n=0 means 2**WIDTH) with enable, parallel load,
// one-shot/continuous mode, a one-cycle terminal-count pulse and a saturating
// count of terminal ticks.
// Optional feature macro: MODN_PRESCALER_EN -- adds psc and a modn_prescaler so
// a tick needs psc+1 enabled RUN cycles.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  prog_modn_counter_if.slave: controls in, count/tc/busy/done/wraps/state out
// All outputs are registered; command-to-output latency is one cycle.
// Same-cycle priority: rst > clr > load > start > stop > tick.
module prog_modn_counter
  import prog_modn_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
`ifdef MODN_PRESCALER_EN
  , parameter int PSC_W = PSC_W_DEF
`endif
) (
  input logic                clk,
  input logic                rst,
  prog_modn_counter_if.slave bus
);

  modn_state_t       state;
  logic [WIDTH-1:0]  count_q;
  logic              tc_q;
  logic              busy_q;
  logic              done_q;
  logic [WRAP_W-1:0] wraps_q;

  logic [WIDTH-1:0]  last;
  logic              tick;
  logic              strobe;
  logic [WIDTH-1:0]  next_count;
  logic              terminal;

  // n=0 wraps to all-ones, giving the full 2**WIDTH range
  assign last = bus.n - 1'b1;

`ifdef MODN_PRESCALER_EN
  modn_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.clr | bus.start | bus.load),
    .en     ((state == RUN) & bus.en),
    .psc    (bus.psc),
    .strobe (strobe)
  );
`else
  assign strobe = 1'b1;
`endif

  assign tick = (state == RUN) & bus.en & strobe;

  // Next count for a tick. A count above last (n reduced mid-run) wraps to 0
  // when counting up, but is only pulled back to last when counting down.
  always_comb begin
    next_count = count_q;
    terminal   = 1'b0;
    if (!bus.down) begin
      if (count_q >= last) begin
        next_count = '0;
        terminal   = 1'b1;
      end else begin
        next_count = count_q + 1'b1;
      end
    end else begin
      if (count_q == '0) begin
        next_count = last;
        terminal   = 1'b1;
      end else if (count_q > last) begin
        next_count = last;
      end else begin
        next_count = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else if (bus.clr) begin
      state   <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        count_q <= (bus.load_val > last) ? last : bus.load_val;
      end else if (bus.start) begin
        state   <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        count_q <= bus.down ? last : '0;
      end else if (bus.stop && state != IDLE) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (tick) begin
        count_q <= next_count;
        if (terminal) begin
          tc_q <= 1'b1;
          if (wraps_q != '1) wraps_q <= wraps_q + 1'b1;
          if (bus.one_shot) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wraps = wraps_q;
  assign bus.state = state;

endmodule

// File: tb/tb_prog_modn_counter.sv
// Testbench for prog_modn_counter (default parameters, WIDTH=10, WRAP_W=8).
// Expected {tc, busy, done, count} words are pushed to exp_q as each cycle of
// stimulus is driven and popped when the DUT output for that cycle is sampled
// (1 time unit after the rising edge). The prescaler test is only compiled
// when MODN_PRESCALER_EN is defined.
module tb_prog_modn_counter;
  import prog_modn_counter_pkg::*;

  localparam int WIDTH = 10;
  localparam int EW    = WIDTH + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_modn_counter_if bus ();

  prog_modn_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp;
  logic [EW-1:0] got;
  int checks = 0;
  int errors = 0;

  function automatic logic [EW-1:0] mk(logic t, logic b, logic d, int c);
    return {t, b, d, c[WIDTH-1:0]};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {bus.tc, bus.busy, bus.done, bus.count};
  endfunction

  task automatic drive_idle();
    bus.clr = 0; bus.start = 0; bus.stop = 0; bus.en = 1; bus.down = 0;
    bus.one_shot = 0; bus.load = 0; bus.load_val = '0; bus.n = 10'd30;
`ifdef MODN_PRESCALER_EN
    bus.psc = '0;
`endif
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", obs(), mk(0, 0, 0, 0));
    end
    checks++;
    if (bus.wraps !== 8'd0) begin
      errors++; $display("FAIL reset_wraps got=%0d exp=0", bus.wraps);
    end
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_up_continuous();
    bus.start = 1;
    exp_q.push_back(mk(0, 1, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL up_start got=%h exp=%h", got, exp);
    end
    bus.start = 0;
    for (int k = 1; k <= 65; k++) begin
      exp_q.push_back(mk((k % 30) == 0, 1, 0, k % 30));
      @(posedge clk); #1;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL up_cont k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    checks++;
    if (bus.wraps !== 8'd2) begin
      errors++; $display("FAIL up_wraps got=%0d exp=2", bus.wraps);
    end
    bus.stop = 1;
    exp_q.push_back(mk(0, 0, 0, 5));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL up_stop_hold got=%h exp=%h", got, exp);
    end
    bus.stop = 0;
  endtask

  task automatic test_down_one_shot();
    bus.clr = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp || bus.wraps !== 8'd0) begin
      errors++; $display("FAIL ds_clr got=%h exp=%h wraps=%0d exp=0", got, exp, bus.wraps);
    end
    bus.clr = 0; bus.down = 1; bus.one_shot = 1; bus.start = 1;
    for (int k = 0; k <= 29; k++) begin
      exp_q.push_back(mk(0, 1, 0, 29 - k));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ds_count k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(k == 0, 0, 1, 29));
      @(posedge clk); #1;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ds_done k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    checks++;
    if (bus.wraps !== 8'd1) begin
      errors++; $display("FAIL ds_wraps got=%0d exp=1", bus.wraps);
    end
    bus.stop = 1;
    exp_q.push_back(mk(0, 0, 0, 29));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL ds_stop got=%h exp=%h", got, exp);
    end
    bus.stop = 0; bus.down = 0; bus.one_shot = 0;
  endtask

  task automatic test_shrink();
    bus.start = 1;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(mk(0, 1, 0, k));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL shrink_run k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    bus.n = 10'd10;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(mk((k % 10) == 0, 1, 0, k % 10));
      @(posedge clk); #1;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL shrink_period k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_load();
    logic [EW-1:0] plan[5];
    // count is 0 and running with n=10; n goes back to 30 with the load
    bus.n = 10'd30; bus.load = 1; bus.load_val = 10'd50;
    plan[0] = mk(0, 1, 0, 29);
    plan[1] = mk(1, 1, 0, 0);
    plan[2] = mk(0, 0, 0, 0);
    plan[3] = mk(0, 0, 0, 7);
    plan[4] = mk(0, 0, 0, 7);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(plan[k]);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL load k=%0d got=%h exp=%h", k, got, exp);
      end
      bus.load = (k == 2); bus.load_val = 10'd7; bus.stop = (k == 1);
    end
    bus.load = 0; bus.stop = 0;
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] plan[14];
    logic [3:0]    st[14];
    // st bits: {en_off, down, stop, start} applied before each edge
    st[0] = 4'b0001; plan[0] = mk(0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin st[k] = 4'b0000; plan[k] = mk(0, 1, 0, k); end
    st[6]  = 4'b0001; plan[6]  = mk(0, 1, 0, 0);
    st[7]  = 4'b0011; plan[7]  = mk(0, 1, 0, 0);
    st[8]  = 4'b0000; plan[8]  = mk(0, 1, 0, 1);
    st[9]  = 4'b1000; plan[9]  = mk(0, 1, 0, 1);
    st[10] = 4'b1000; plan[10] = mk(0, 1, 0, 1);
    st[11] = 4'b0101; plan[11] = mk(0, 1, 0, 29);
    st[12] = 4'b0100; plan[12] = mk(0, 1, 0, 28);
    st[13] = 4'b0000; plan[13] = mk(0, 1, 0, 29);
    for (int k = 0; k < 14; k++) begin
      bus.start = st[k][0]; bus.stop = st[k][1]; bus.down = st[k][2]; bus.en = !st[k][3];
      exp_q.push_back(plan[k]);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    bus.start = 1;
    for (int k = 0; k <= 3; k++) begin
      exp_q.push_back(mk(0, 1, 0, k));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ar_run k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0) || bus.wraps !== 8'd0) begin
      errors++; $display("FAIL ar_immediate got=%h exp=%h wraps=%0d", obs(), mk(0, 0, 0, 0), bus.wraps);
    end
    #1 rst = 1'b0;
    bus.stop = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL ar_stop got=%h exp=%h", got, exp);
    end
    bus.stop = 0; bus.start = 1;
    for (int k = 0; k <= 2; k++) begin
      exp_q.push_back(mk(0, 1, 0, k));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ar_resume k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_wraps_sat();
    bus.clr = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL ws_clr got=%h exp=%h", got, exp);
    end
    bus.clr = 0; bus.n = 10'd1; bus.start = 1;
    for (int k = 0; k <= 300; k++) begin
      exp_q.push_back(mk(k != 0, 1, 0, 0));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ws_tick k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    checks++;
    if (bus.wraps !== 8'd255) begin
      errors++; $display("FAIL ws_saturate got=%0d exp=255", bus.wraps);
    end
    bus.clr = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    exp = exp_q.pop_front(); got = obs(); checks++;
    if (got !== exp || bus.wraps !== 8'd0 || bus.state !== IDLE) begin
      errors++; $display("FAIL ws_clr_after got=%h exp=%h wraps=%0d state=%0d", got, exp, bus.wraps, bus.state);
    end
    bus.clr = 0; bus.n = 10'd30;
  endtask

`ifdef MODN_PRESCALER_EN
  task automatic test_prescaler();
    bus.psc = 8'd3; bus.start = 1;
    for (int k = 0; k <= 13; k++) begin
      exp_q.push_back(mk(0, 1, 0, k / 4));
      @(posedge clk); #1;
      bus.start = 0;
      exp = exp_q.pop_front(); got = obs(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL psc k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    bus.psc = '0; bus.stop = 1;
    @(posedge clk); #1;
    bus.stop = 0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_continuous();
    test_down_one_shot();
    test_shrink();
    test_load();
    test_back_to_back();
    test_async_reset();
    test_wraps_sat();
`ifdef MODN_PRESCALER_EN
    test_prescaler();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
